// File: rtl/pipeline_hazard_unit.sv
// Forwarding-select and load-use hazard unit: a shift register of in-flight destination tokens from EX onward.
// Optional feature macro HAZARD_PERF_CNT_EN adds the stall_cnt / fwd_cnt performance counters.
module pipeline_hazard_unit_chk #(
    parameter int NUM_SRC    = 2,
    parameter int FWD_DEPTH  = 2,
    parameter int LOAD_STAGE = 2,
    parameter int SEL_W      = 2
) (
    input logic                     clk,
    input logic                     rst_n,
    input logic [FWD_DEPTH:0]       valid_q,
    input logic [FWD_DEPTH:0]       memread_q,
    input logic [NUM_SRC*SEL_W-1:0] fwd_sel
);
    logic bad_s;

    // Flags any operand selecting a load that has not yet reached its data-ready stage
    always_comb begin
        bad_s = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = 1; k <= FWD_DEPTH; k++) begin
                if ((fwd_sel[i*SEL_W +: SEL_W] == SEL_W'(k)) && valid_q[k] && memread_q[k] && (k < LOAD_STAGE)) begin
                    bad_s = 1'b1;
                end else begin
                    bad_s = bad_s;
                end
            end
        end
    end

    a_no_early_load_fwd: assert property (@(posedge clk) disable iff (!rst_n) !bad_s);
endmodule

module pipeline_hazard_unit #(
    parameter int  REG_ADDR_W = 5,
    parameter int  NUM_SRC    = 2,
    parameter int  FWD_DEPTH  = 2,
    parameter int  LOAD_STAGE = 2,
    localparam int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
    input  logic [NUM_SRC-1:0]            id_rs_used,
    input  logic [REG_ADDR_W-1:0]         id_rd,
    input  logic                          id_regwrite,
    input  logic                          id_memread,
    input  logic                          flush,
    input  logic                          ext_stall,
    output logic                          hz_stall,
    output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
    output logic                          ex_bubble
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]                   stall_cnt,
    output logic [31:0]                   fwd_cnt
`endif
);
    localparam int NPOS = FWD_DEPTH + 1;

    logic [NPOS-1:0]               valid_q, valid_d;
    logic [NPOS-1:0]               regwrite_q, regwrite_d;
    logic [NPOS-1:0]               memread_q, memread_d;
    logic [REG_ADDR_W-1:0]         rd_q [NPOS];
    logic [REG_ADDR_W-1:0]         rd_d [NPOS];
    // Source fields only matter for the token sitting in EX
    logic [NUM_SRC*REG_ADDR_W-1:0] ex_rs_q, ex_rs_d;
    logic [NUM_SRC-1:0]            ex_rs_used_q, ex_rs_used_d;

    logic [NPOS-1:0]               elig_s;
    logic                          load_hit_s;
    logic                          hz_stall_s;
    logic                          ex_bubble_s;
    logic [NUM_SRC*SEL_W-1:0]      fwd_sel_s;

    // Producer eligibility per position
    always_comb begin
        for (int p = 0; p < NPOS; p++) begin
            elig_s[p] = valid_q[p] && regwrite_q[p] && (rd_q[p] != {REG_ADDR_W{1'b0}});
        end
    end

    // Youngest-wins forwarding select: scan oldest to youngest so the nearest match overwrites
    always_comb begin
        fwd_sel_s = {(NUM_SRC*SEL_W){1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = FWD_DEPTH; k >= 1; k--) begin
                if (valid_q[0] && ex_rs_used_q[i] && elig_s[k] && (rd_q[k] == ex_rs_q[i*REG_ADDR_W +: REG_ADDR_W])) begin
                    fwd_sel_s[i*SEL_W +: SEL_W] = SEL_W'(k);
                end else begin
                    fwd_sel_s[i*SEL_W +: SEL_W] = fwd_sel_s[i*SEL_W +: SEL_W];
                end
            end
        end
    end

    // Load-use detection against loads whose data is not forwardable by the time ID reaches EX
    always_comb begin
        load_hit_s = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int p = 0; p < NPOS; p++) begin
                if ((p + 2 <= LOAD_STAGE) && id_rs_used[i]
                    && (id_rs[i*REG_ADDR_W +: REG_ADDR_W] != {REG_ADDR_W{1'b0}})
                    && elig_s[p] && memread_q[p]
                    && (rd_q[p] == id_rs[i*REG_ADDR_W +: REG_ADDR_W])) begin
                    load_hit_s = 1'b1;
                end else begin
                    load_hit_s = load_hit_s;
                end
            end
        end
        hz_stall_s  = id_valid && !flush && load_hit_s;
        ex_bubble_s = flush || hz_stall_s || !id_valid;
    end

    // Token shift: advance unless the whole pipe is frozen
    always_comb begin
        valid_d      = valid_q;
        regwrite_d   = regwrite_q;
        memread_d    = memread_q;
        rd_d         = rd_q;
        ex_rs_d      = ex_rs_q;
        ex_rs_used_d = ex_rs_used_q;
        if (!ext_stall) begin
            for (int k = 1; k < NPOS; k++) begin
                valid_d[k]    = valid_q[k-1];
                regwrite_d[k] = regwrite_q[k-1];
                memread_d[k]  = memread_q[k-1];
                rd_d[k]       = rd_q[k-1];
            end
            valid_d[0]    = !ex_bubble_s;
            regwrite_d[0] = id_regwrite && !ex_bubble_s;
            memread_d[0]  = id_memread && !ex_bubble_s;
            rd_d[0]       = id_rd;
            ex_rs_d       = id_rs;
            ex_rs_used_d  = ex_bubble_s ? {NUM_SRC{1'b0}} : id_rs_used;
        end else begin
            valid_d = valid_q;
        end
    end

    // Token state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= {NPOS{1'b0}};
            regwrite_q   <= {NPOS{1'b0}};
            memread_q    <= {NPOS{1'b0}};
            ex_rs_q      <= {(NUM_SRC*REG_ADDR_W){1'b0}};
            ex_rs_used_q <= {NUM_SRC{1'b0}};
            for (int p = 0; p < NPOS; p++) begin
                rd_q[p] <= {REG_ADDR_W{1'b0}};
            end
        end else begin
            valid_q      <= valid_d;
            regwrite_q   <= regwrite_d;
            memread_q    <= memread_d;
            ex_rs_q      <= ex_rs_d;
            ex_rs_used_q <= ex_rs_used_d;
            rd_q         <= rd_d;
        end
    end

    assign hz_stall  = hz_stall_s;
    assign ex_bubble = ex_bubble_s;
    assign fwd_sel   = fwd_sel_s;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] fwd_cnt_q, fwd_cnt_d;

    // Counter next-state; both wrap naturally at 2^32
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (hz_stall_s && !ext_stall) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (!ext_stall && (|fwd_sel_s)) begin
            fwd_cnt_d = fwd_cnt_q + 32'd1;
        end else begin
            fwd_cnt_d = fwd_cnt_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
            fwd_cnt_q   <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`endif

    pipeline_hazard_unit_chk #(
        .NUM_SRC    (NUM_SRC),
        .FWD_DEPTH  (FWD_DEPTH),
        .LOAD_STAGE (LOAD_STAGE),
        .SEL_W      (SEL_W)
    ) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_q   (valid_q),
        .memread_q (memread_q),
        .fwd_sel   (fwd_sel_s)
    );
endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit: default instance plus a FWD_DEPTH=3/LOAD_STAGE=3 instance on shared stimulus,
// checked against an instruction-history model every cycle and by directed literal expectations.
module tb_pipeline_hazard_unit;
    localparam int W  = 5;
    localparam int NS = 2;
    localparam int DA = 2, LA = 2, DB = 3, LB = 3;
    localparam int SA = $clog2(DA + 1);
    localparam int SB = $clog2(DB + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic id_valid = 1'b0;
    logic [NS*W-1:0] id_rs = '0;
    logic [NS-1:0] id_rs_used = '0;
    logic [W-1:0] id_rd = '0;
    logic id_regwrite = 1'b0, id_memread = 1'b0, flush = 1'b0, ext_stall = 1'b0;
    logic hz_a, hz_b, bub_a, bub_b;
    logic [NS*SA-1:0] fwd_a;
    logic [NS*SB-1:0] fwd_b;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] sc_a, fc_a, sc_b, fc_b;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipeline_hazard_unit dut_a (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .ext_stall(ext_stall), .hz_stall(hz_a), .fwd_sel(fwd_a), .ex_bubble(bub_a)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(sc_a), .fwd_cnt(fc_a)
`endif
    );

    pipeline_hazard_unit #(.FWD_DEPTH(DB), .LOAD_STAGE(LB)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .ext_stall(ext_stall), .hz_stall(hz_b), .fwd_sel(fwd_b), .ex_bubble(bub_b)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(sc_b), .fwd_cnt(fc_b)
`endif
    );

    // One record per instruction slot that has entered EX; index 0 = most recent (EX), index p = p stages later
    typedef struct {
        bit v;
        bit rw;
        bit mr;
        int rd;
        int rs0;
        int rs1;
        bit u0;
        bit u1;
    } tok_t;

    tok_t qa[$];
    tok_t qb[$];
    int sc_exp[2];
    int fc_exp[2];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic tok_t at(input int m, input int p);
        tok_t t;
        t = '{default: 0};
        if (m == 0 && p < qa.size()) t = qa[p];
        if (m == 1 && p < qb.size()) t = qb[p];
        return t;
    endfunction

    function automatic bit elig(input tok_t t);
        return t.v && t.rw && (t.rd != 0);
    endfunction

    function automatic int model_fwd(input int m, input int opnd);
        tok_t ex, t;
        int depth, rs;
        bit u;
        ex = at(m, 0);
        depth = (m == 0) ? DA : DB;
        rs = (opnd == 0) ? ex.rs0 : ex.rs1;
        u = (opnd == 0) ? ex.u0 : ex.u1;
        if (!ex.v || !u) return 0;
        for (int k = 1; k <= depth; k++) begin
            t = at(m, k);
            if (elig(t) && t.rd == rs) return k;
        end
        return 0;
    endfunction

    function automatic bit model_stall(input int m);
        tok_t t;
        int ls, rs;
        ls = (m == 0) ? LA : LB;
        if (!id_valid || flush) return 1'b0;
        for (int i = 0; i < NS; i++) begin
            rs = int'(id_rs[i*W +: W]);
            if (id_rs_used[i] && rs != 0) begin
                for (int p = 0; p <= ls - 2; p++) begin
                    t = at(m, p);
                    if (elig(t) && t.mr && t.rd == rs) return 1'b1;
                end
            end
        end
        return 1'b0;
    endfunction

    // Model history update on each advancing edge
    always @(posedge clk or negedge rst_n) begin
        tok_t nt [2];
        if (!rst_n) begin
            qa.delete();
            qb.delete();
            sc_exp <= '{0, 0};
            fc_exp <= '{0, 0};
        end else if (!ext_stall) begin
            for (int m = 0; m < 2; m++) begin
                nt[m].v   = !(flush || model_stall(m) || !id_valid);
                nt[m].rw  = id_regwrite;
                nt[m].mr  = id_memread;
                nt[m].rd  = int'(id_rd);
                nt[m].rs0 = int'(id_rs[W-1:0]);
                nt[m].rs1 = int'(id_rs[2*W-1:W]);
                nt[m].u0  = id_rs_used[0];
                nt[m].u1  = id_rs_used[1];
                if (model_stall(m)) sc_exp[m] <= sc_exp[m] + 1;
                if (model_fwd(m, 0) != 0 || model_fwd(m, 1) != 0) fc_exp[m] <= fc_exp[m] + 1;
            end
            qa.push_front(nt[0]);
            qb.push_front(nt[1]);
            if (qa.size() > 6) void'(qa.pop_back());
            if (qb.size() > 6) void'(qb.pop_back());
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            chk("hz_stall_a", hz_a, model_stall(0));
            chk("ex_bubble_a", bub_a, flush || model_stall(0) || !id_valid);
            chk("fwd_sel_a0", fwd_a[SA-1:0], model_fwd(0, 0));
            chk("fwd_sel_a1", fwd_a[2*SA-1:SA], model_fwd(0, 1));
            chk("hz_stall_b", hz_b, model_stall(1));
            chk("ex_bubble_b", bub_b, flush || model_stall(1) || !id_valid);
            chk("fwd_sel_b0", fwd_b[SB-1:0], model_fwd(1, 0));
            chk("fwd_sel_b1", fwd_b[2*SB-1:SB], model_fwd(1, 1));
`ifdef HAZARD_PERF_CNT_EN
            chk("stall_cnt_a", sc_a, sc_exp[0]);
            chk("fwd_cnt_a", fc_a, fc_exp[0]);
            chk("stall_cnt_b", sc_b, sc_exp[1]);
            chk("fwd_cnt_b", fc_b, fc_exp[1]);
`endif
        end
    end

    task automatic put(input bit v, input int rd, input int rs0, input int rs1,
                       input bit u0, input bit u1, input bit rw, input bit mr);
        id_valid    = v;
        id_rd       = W'(rd);
        id_rs       = {W'(rs1), W'(rs0)};
        id_rs_used  = {u1, u0};
        id_regwrite = rw;
        id_memread  = mr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bubbles(input int n);
        put(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) tick();
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_hz_a", hz_a, 0);
        chk("rst_bub_a", bub_a, 1);
        chk("rst_fwd_a", fwd_a, 0);
        chk("rst_fwd_b", fwd_b, 0);
`ifdef HAZARD_PERF_CNT_EN
        chk("rst_stall_cnt", sc_a, 0);
        chk("rst_fwd_cnt", fc_a, 0);
`endif
        #6 rst_n = 1'b1;
        tick();

        // Back-to-back ALU dependency: add x5 ; add x6,x5,x5
        put(1, 5, 1, 2, 1, 1, 1, 0); tick();
        put(1, 6, 5, 5, 1, 1, 1, 0); #1;
        chk("b2b_nostall", hz_a, 0);
        tick(); put(0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("b2b_fwd_a", fwd_a, 5);
        chk("b2b_fwd_b", fwd_b, 5);

        // Two writers of x5: youngest wins
        bubbles(4);
        put(1, 5, 1, 1, 1, 1, 1, 0); tick();
        put(1, 5, 2, 2, 1, 1, 1, 0); tick();
        put(1, 7, 5, 5, 1, 1, 1, 0); tick();
        put(0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("youngest_fwd", fwd_a, 5);

        // Consumer two behind, no newer writer
        bubbles(4);
        put(1, 5, 1, 1, 1, 1, 1, 0); tick();
        put(1, 10, 1, 1, 1, 1, 1, 0); tick();
        put(1, 11, 5, 0, 1, 0, 1, 0); tick();
        put(0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("dist2_fwd_a", fwd_a, 2);
        chk("dist2_fwd_b", fwd_b, 2);

        // lw x7 ; add x8,x7,x0
        bubbles(4);
        put(1, 7, 1, 0, 1, 0, 1, 1); tick();
        put(1, 8, 7, 0, 1, 1, 1, 0); #1;
        chk("lu_hz_a_c1", hz_a, 1);
        chk("lu_bub_a_c1", bub_a, 1);
        chk("lu_hz_b_c1", hz_b, 1);
        tick(); #1;
        chk("lu_hz_a_c2", hz_a, 0);
        chk("lu_bub_a_c2", bub_a, 0);
        chk("lu_hz_b_c2", hz_b, 1);
        tick(); #1;
        chk("lu_fwd_a", fwd_a, 2);
        chk("lu_hz_b_c3", hz_b, 0);
        tick(); put(0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("lu_fwd_b", fwd_b, 3);

        // x0 writer/reader, regwrite=0 producer, unused operands, load to x0
        bubbles(4);
        put(1, 0, 1, 1, 1, 1, 1, 0); tick();
        put(1, 11, 0, 0, 1, 1, 1, 0); #1;
        chk("x0_nostall", hz_a, 0);
        tick(); #1;
        chk("x0_fwd", fwd_a, 0);
        put(1, 12, 1, 1, 1, 1, 0, 0); tick();
        put(1, 13, 12, 12, 1, 1, 1, 0); tick(); #1;
        chk("norw_fwd", fwd_a, 0);
        put(1, 14, 1, 1, 1, 1, 1, 0); tick();
        put(1, 15, 14, 14, 0, 0, 1, 0); tick(); #1;
        chk("unused_fwd", fwd_a, 0);
        put(1, 0, 1, 0, 1, 0, 1, 1); tick();
        put(1, 9, 0, 0, 1, 1, 1, 0); #1;
        chk("ldx0_nostall", hz_a, 0);

        // Load-use with flush in the same cycle
        bubbles(4);
        put(1, 7, 1, 0, 1, 0, 1, 1); tick();
        put(1, 8, 7, 0, 1, 1, 1, 0); flush = 1'b1; #1;
        chk("flush_hz_a", hz_a, 0);
        chk("flush_bub_a", bub_a, 1);
        chk("flush_hz_b", hz_b, 0);
        tick(); flush = 1'b0; put(0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("flush_fwd", fwd_a, 0);

        // ext_stall held three cycles during a load-use stall
        bubbles(4);
        put(1, 7, 1, 0, 1, 0, 1, 1); tick();
        put(1, 8, 7, 0, 1, 1, 1, 0); #1;
        chk("es_hz_pre", hz_a, 1);
        ext_stall = 1'b1;
        tick(); #1; chk("es_hz_f1", hz_a, 1);
        tick(); #1; chk("es_hz_f2", hz_a, 1);
        tick(); ext_stall = 1'b0; #1;
        chk("es_hz_resume", hz_a, 1);
        tick(); #1;
        chk("es_hz_done", hz_a, 0);
        chk("es_bub_done", bub_a, 0);
        tick(); put(0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("es_fwd", fwd_a, 2);

        // Asynchronous reset mid-stall
        bubbles(4);
        put(1, 5, 1, 2, 1, 1, 1, 0); tick();
        put(1, 7, 5, 0, 1, 0, 1, 1); tick();
        put(1, 8, 7, 0, 1, 1, 1, 0); #1;
        chk("ar_fwd_pre", fwd_a, 1);
        chk("ar_hz_pre", hz_a, 1);
        #1 rst_n = 1'b0; id_valid = 1'b0;
        #1;
        chk("ar_hz", hz_a, 0);
        chk("ar_bub", bub_a, 1);
        chk("ar_fwd_a", fwd_a, 0);
        chk("ar_fwd_b", fwd_b, 0);
        @(negedge clk); #1 rst_n = 1'b1;
        put(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef HAZARD_PERF_CNT_EN
        #1;
        chk("ar_stall_cnt", sc_a, 0);
        chk("ar_fwd_cnt", fc_a, 0);
`endif
        tick();
        put(1, 7, 1, 0, 1, 0, 1, 1); tick();
        put(1, 8, 7, 0, 1, 1, 1, 0); tick();
        tick();
        tick();
        put(0, 0, 0, 0, 0, 0, 0, 0); tick(); #1;
`ifdef HAZARD_PERF_CNT_EN
        chk("seq_stall_cnt_a", sc_a, 1);
        chk("seq_fwd_cnt_a", fc_a, 1);
        chk("seq_stall_cnt_b", sc_b, 2);
        chk("seq_fwd_cnt_b", fc_b, 1);
`endif
        chk("seq_end_hz_b", hz_b, 0);
        bubbles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_unit.md
# pipeline_hazard_unit

Parametrised forwarding and hazard-detection unit for the pipelined RISC-V core. It tracks destination-register tokens for in-flight instructions from EX through FWD_DEPTH later stages. From those tokens it drives per-operand forwarding selects for the EX stage. It also raises a load-use stall for the ID stage, inserts bubbles, and honours flush and external freeze requests.

## Interface
- REG_ADDR_W, 5, register address width
- NUM_SRC, 2, source operands per instruction
- FWD_DEPTH, 2, forwarding stages after EX (1 = EX/MEM, 2 = MEM/WB, …); SEL_W = $clog2(FWD_DEPTH+1)
- LOAD_STAGE, 2, first stage index (1..FWD_DEPTH) at which load data can be forwarded

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  valid instruction in ID
- id_rs  in  NUM_SRC*REG_ADDR_W  ID source addresses, operand i at [i*REG_ADDR_W +: REG_ADDR_W]
- id_rs_used  in  NUM_SRC  operand i actually read
- id_rd  in  REG_ADDR_W  ID destination
- id_regwrite  in  1  ID instruction writes rd
- id_memread  in  1  ID instruction is a load
- flush  in  1  kill the ID instruction (branch/jump redirect)
- ext_stall  in  1  freeze the whole pipeline (memory wait)
- hz_stall  out  1  load-use stall: hold PC and IF/ID
- fwd_sel  out  NUM_SRC*SEL_W  per EX operand: 0 = register file, k = stage k result
- ex_bubble  out  1  the token entering EX on the next edge is a bubble

## Operation
- Token holds valid, rd, regwrite, memread, rs[NUM_SRC], rs_used. Position 0 is EX; positions 1..FWD_DEPTH are the later stages.
- Producer at position p is eligible when: valid && regwrite && rd != 0.
- fwd_sel[i]: when the EX token's rs_used[i] is set, it is the smallest k in 1..FWD_DEPTH whose eligible producer rd equals EX rs[i]. Otherwise it is 0, the youngest-wins rule.
- Data beyond FWD_DEPTH comes from the register file, which has write-before-read.
- hz_stall = id_valid && !flush && any used ID source i has rs[i] != 0 matching an eligible producer with memread at position p ≤ LOAD_STAGE-2. LOAD_STAGE = 1 never stalls.
- ex_bubble = flush || hz_stall || !id_valid.
- Advance (ext_stall = 0):
  - position k ← position k-1 for k ≥ 1;
  - position 0 ← ID token, or an invalid token if ex_bubble;
  - the token shifted past FWD_DEPTH is dropped.
- ext_stall = 1: all tokens and counters hold. hz_stall and fwd_sel still reflect current state.
- flush and hz_stall same cycle: flush wins and hz_stall = 0.

## Timing
- Reset (async on rst_n low): all tokens invalid, fwd_sel = 0, hz_stall = 0, ex_bubble = 1 (id_valid is 0 in reset), counters 0.
- Token state updates on the rising edge of clk.
- fwd_sel is combinational from registered state only, valid from the start of the cycle.
- hz_stall and ex_bubble are combinational from the ID inputs plus state, with no registered outputs.
- Producer-to-consumer forwarding latency:
  - back-to-back ALU consumer sees fwd_sel = 1 with no stall;
  - LOAD_STAGE = 2 load gives exactly one stall cycle, then fwd_sel = 2.
- A load-use stall lasts LOAD_STAGE-1 cycles (ext_stall cycles excluded). Stall deasserts in the cycle the producer reaches position LOAD_STAGE-1.
- Invariant (assertion): no load token at position < LOAD_STAGE is ever selected by fwd_sel.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - adds outputs stall_cnt[31:0], counting cycles with hz_stall && !ext_stall;
  - adds fwd_cnt[31:0], counting advancing cycles with any nonzero fwd_sel;
  - both wrap at 2^32 and reset to 0.
- Not defined: ports and counters are absent; no other behaviour changes.

## Test plan
- Default params. add x5 then add x6,x5,x5 back-to-back -> no stall, EX fwd_sel = {1,1}.
- Same rd written by two instructions, producers x5 at positions 1 and 2 -> fwd_sel = 1 (youngest). Consumer two behind with no newer writer -> fwd_sel = 2.
- lw x7, then add x8,x7,x0 -> hz_stall = 1 for one cycle with ex_bubble = 1, then fwd_sel[0] = 2 and fwd_sel[1] = 0. With LOAD_STAGE = 3, FWD_DEPTH = 3 -> two stall cycles, then fwd_sel[0] = 3.
- Writer to x0, reader of x0; regwrite = 0 producer; rs_used = 0 operand -> fwd_sel = 0, no stall.
- Load-use stall with flush asserted in the same cycle -> hz_stall = 0 and a bubble in EX. ext_stall held 3 cycles mid-stall -> tokens frozen, stall resumes afterwards for exactly the remaining cycle.
- rst_n pulsed low mid-stall (asynchronous, between edges) -> outputs immediately reset. With HAZARD_PERF_CNT_EN, stall_cnt and fwd_cnt read 0 and then count the directed sequence exactly.
